max11046_read_ctrl: RTL and testbench
=====================================

// Module: max11046_read_ctrl
// PURPOSE
//  Upstream stage of the MAX11046 shift-out serializer. Runs one ADC frame per Start:
//  CONVST pulse, wait for EOC, then CS/RD burst-read of NUM_CH parallel words.
//  Each word goes to the serializer as Dout (its Din) plus the endof_con load/shift strobe:
//  low = load, high = shift one bit per Clock.
//  Flags conversion timeouts.
// PARAMETERS
//  DW             16    ADC word width; also the shift-phase length in cycles
//  NUM_CH         8     channels read per frame (1..8)
//  CONVST_LOW_CYC 4     Clock cycles CONVST_n held low
//  RD_LOW_CYC     3     Clock cycles RD_n held low per word (>=2)
//  EOC_TIMEOUT    1000  max cycles in WAIT_EOC before abort
// PORTS
//  Clock      in   1   system clock; all logic posedge (serializer samples on negedge)
//  Reset      in   1   asynchronous, active-low reset
//  Start      in   1   frame request, sampled in IDLE only
//  EOC_n      in   1   ADC end-of-conversion, asynchronous, active-low
//  DB         in   DW  ADC parallel data bus
//  CONVST_n   out  1   ADC convert start, active-low
//  CS_n       out  1   ADC chip select, active-low
//  RD_n       out  1   ADC read strobe, active-low
//  Dout       out  DW  latched word -> serializer Din
//  endof_con  out  1   0 = serializer loads Dout, 1 = serializer shifts
//  Ch         out  3   index of word currently in Dout
//  Busy       out  1   high from first cycle after Start accepted until IDLE re-entered
//  Done       out  1   1-cycle pulse: last word fully shifted
//  Timeout    out  1   1-cycle pulse: EOC not seen within EOC_TIMEOUT
// BEHAVIOUR
//  Reset (async, any state) forces these outputs:
//   CONVST_n=1, CS_n=1, RD_n=1; endof_con=0; Dout=0; Ch=0.
//   Busy=0, Done=0, Timeout=0; FSM=IDLE; counters=0; sync FFs=1.
//  States:
//   IDLE: Start=1 -> CONV.
//   CONV: CONVST_n=0 for CONVST_LOW_CYC cycles -> WAIT_EOC (CONVST_n=1).
//   WAIT_EOC: synced falling edge of EOC_n -> RD_LOW. Counter reaching EOC_TIMEOUT -> Timeout pulse, IDLE.
//   RD_LOW: CS_n=0, RD_n=0 for RD_LOW_CYC cycles. DB captured into Dout on the last posedge of the phase.
//           Next cycle RD_n=1 -> LOAD.
//   LOAD: endof_con=0 for 1 cycle -> SHIFT.
//   SHIFT: endof_con=1 for exactly DW cycles. Then:
//          Ch<NUM_CH-1 -> Ch+1, RD_LOW;
//          else Done pulse, CS_n=1, Ch=0, IDLE.
//  EOC_n path: 2-FF synchronizer, then edge detect. Only a high->low edge seen while in WAIT_EOC counts.
//  EOC_n already low on WAIT_EOC entry is stale; it is ignored until it goes high then low.
//  EOC latency: 3 cycles from the async EOC_n fall to RD_n=0.
//  Start is ignored while Busy. Start held high gives back-to-back frames with exactly 1 IDLE cycle between.
//  CS_n stays low continuously from the first RD_LOW to the end of the last SHIFT.
//  Per-frame read length: NUM_CH*(RD_LOW_CYC+1+DW) cycles after the EOC edge is detected.
//  Counters are sized with $clog2 of their maximum; no wrap is possible inside a state.
//  Dout holds its value outside RD_LOW, so the serializer sees a stable Din.
// STRUCTURE
//  max11046_defs.vh: FSM state localparams (IDLE, CONV, WAIT_EOC, RD_LOW, LOAD, SHIFT) and DW default.
//  Shared by this block and the serializer.
//  Sub-module max11046_eoc_sync: 2-FF synchronizer plus falling-edge pulse.
//  Async active-low reset to 1.
//  FSM, phase counter, channel counter and timeout counter stay inline.
// TESTING (defaults; bench chains this block to the serializer on the same Clock)
//  1 Reset mid-frame (Reset=0 in SHIFT of Ch=3) -> all outputs at reset values the same cycle.
//    The next Start reads from Ch=0.
//  2 Start pulse; ADC model drops EOC_n 50 cycles after CONVST_n rises; DB=16'hA500+Ch
//    -> 8 RD_n pulses of 3 cycles.
//    Serializer Q emits each word LSB-first over 16 cycles.
//    Done fires 8*20 cycles after the EOC edge is detected.
//  3 EOC_n held high -> Timeout pulse 1000 cycles after WAIT_EOC entry; Busy=0; CS_n never low.
//  4 Start pulsed while Busy -> ignored. Start held high -> second CONVST_n fall 2 cycles after Done.
//  5 EOC_n low before Start, rises 10 cycles into WAIT_EOC, falls at 30 -> first RD_n=0 at cycle 33.

Source files
------------

// File: rtl/max11046_read_ctrl_pkg.sv
// Shared definitions for the MAX11046 read controller: FSM encodings,
// default word width and small elaboration-time helpers.
package max11046_read_ctrl_pkg;

  localparam int DW_DEF = 16;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CONV     = 3'd1;
  localparam logic [2:0] ST_WAIT_EOC = 3'd2;
  localparam logic [2:0] ST_RD_LOW   = 3'd3;
  localparam logic [2:0] ST_LOAD     = 3'd4;
  localparam logic [2:0] ST_SHIFT    = 3'd5;

  // EOC_n is active-low, so the synchronizer idles at the inactive level.
  localparam logic EOC_IDLE_LVL = 1'b1;

  function automatic int max_of3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int clog2_min1(input int x);
    return ($clog2(x) < 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/max11046_eoc_sync.sv
// Two-flop synchronizer for the asynchronous EOC_n input plus a one-cycle
// pulse on each synchronized high-to-low transition.
module max11046_eoc_sync
  import max11046_read_ctrl_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_eoc_n,
  output logic o_eoc_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= EOC_IDLE_LVL;
      r_sync <= EOC_IDLE_LVL;
      r_prev <= EOC_IDLE_LVL;
    end else begin
      r_meta <= i_eoc_n;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  // A level that was already low never produces a pulse; it must rise first.
  assign o_eoc_fall = r_prev & ~r_sync;

endmodule

// File: rtl/max11046_read_ctrl.sv
// MAX11046 frame controller: CONVST pulse, wait for EOC, then a CS/RD burst
// read feeding each word to the downstream shift-out serializer.
module max11046_read_ctrl
  import max11046_read_ctrl_pkg::*;
#(
  parameter int DW             = DW_DEF,
  parameter int NUM_CH         = 8,
  parameter int CONVST_LOW_CYC = 4,
  parameter int RD_LOW_CYC     = 3,
  parameter int EOC_TIMEOUT    = 1000
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_eoc_n,
  input  logic [DW-1:0] i_db,
  output logic          o_convst_n,
  output logic          o_cs_n,
  output logic          o_rd_n,
  output logic [DW-1:0] o_dout,
  output logic          o_endof_con,
  output logic [2:0]    o_ch,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_timeout
);

  localparam int PH_MAX = max_of3(CONVST_LOW_CYC, RD_LOW_CYC, DW);
  localparam int PH_W   = clog2_min1(PH_MAX);
  localparam int TO_W   = clog2_min1(EOC_TIMEOUT + 1);

  localparam logic [PH_W-1:0] CONV_LAST  = PH_W'(CONVST_LOW_CYC - 1);
  localparam logic [PH_W-1:0] RD_LAST    = PH_W'(RD_LOW_CYC - 1);
  localparam logic [PH_W-1:0] SHIFT_LAST = PH_W'(DW - 1);
  localparam logic [2:0]      CH_LAST    = 3'(NUM_CH - 1);
  localparam logic [TO_W-1:0] TO_LIMIT   = TO_W'(EOC_TIMEOUT);

  logic [2:0]      r_state;
  logic [2:0]      w_state_next;
  logic [PH_W-1:0] r_phase;
  logic [PH_W-1:0] w_phase_next;
  logic [2:0]      r_ch;
  logic [2:0]      w_ch_next;
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_next;

  logic            r_convst_n;
  logic            r_cs_n;
  logic            r_rd_n;
  logic            r_endof_con;
  logic            r_busy;
  logic [DW-1:0]   r_dout;

  logic            w_eoc_fall;
  logic            w_to_hit;
  logic            w_capture;
  logic            w_next_reading;

  max11046_eoc_sync u_eoc_sync (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_eoc_n    (i_eoc_n),
    .o_eoc_fall (w_eoc_fall)
  );

  assign w_to_hit  = (r_to_cnt == TO_LIMIT);
  assign w_capture = (r_state == ST_RD_LOW) && (r_phase == RD_LAST);

  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase + 1'b1;
    w_ch_next    = r_ch;
    w_to_next    = '0;
    case (r_state)
      ST_IDLE: begin
        w_phase_next = '0;
        if (i_start) begin
          w_state_next = ST_CONV;
        end
      end
      ST_CONV: begin
        if (r_phase == CONV_LAST) begin
          w_state_next = ST_WAIT_EOC;
          w_phase_next = '0;
        end
      end
      ST_WAIT_EOC: begin
        w_phase_next = '0;
        // A real edge wins over a timeout landing on the same cycle.
        if (w_eoc_fall) begin
          w_state_next = ST_RD_LOW;
        end else if (w_to_hit) begin
          w_state_next = ST_IDLE;
        end else begin
          w_to_next = r_to_cnt + 1'b1;
        end
      end
      ST_RD_LOW: begin
        if (r_phase == RD_LAST) begin
          w_state_next = ST_LOAD;
          w_phase_next = '0;
        end
      end
      ST_LOAD: begin
        w_state_next = ST_SHIFT;
        w_phase_next = '0;
      end
      ST_SHIFT: begin
        if (r_phase == SHIFT_LAST) begin
          w_phase_next = '0;
          if (r_ch == CH_LAST) begin
            w_state_next = ST_IDLE;
            w_ch_next    = '0;
          end else begin
            w_state_next = ST_RD_LOW;
            w_ch_next    = r_ch + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_phase_next = '0;
        w_ch_next    = '0;
      end
    endcase
  end

  // CS_n spans the whole burst so it never toggles between words.
  assign w_next_reading = (w_state_next == ST_RD_LOW) ||
                          (w_state_next == ST_LOAD)   ||
                          (w_state_next == ST_SHIFT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_ch        <= '0;
      r_to_cnt    <= '0;
      r_convst_n  <= 1'b1;
      r_cs_n      <= 1'b1;
      r_rd_n      <= 1'b1;
      r_endof_con <= 1'b0;
      r_busy      <= 1'b0;
      r_dout      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_phase     <= w_phase_next;
      r_ch        <= w_ch_next;
      r_to_cnt    <= w_to_next;
      r_convst_n  <= (w_state_next != ST_CONV);
      r_cs_n      <= !w_next_reading;
      r_rd_n      <= (w_state_next != ST_RD_LOW);
      r_endof_con <= (w_state_next == ST_SHIFT);
      r_busy      <= (w_state_next != ST_IDLE);
      if (w_capture) begin
        r_dout <= i_db;
      end
    end
  end

  assign o_convst_n  = r_convst_n;
  assign o_cs_n      = r_cs_n;
  assign o_rd_n      = r_rd_n;
  assign o_dout      = r_dout;
  assign o_endof_con = r_endof_con;
  assign o_ch        = r_ch;
  assign o_busy      = r_busy;

  // Done marks the final shift cycle itself, one cycle ahead of IDLE.
  assign o_done    = (r_state == ST_SHIFT) && (r_phase == SHIFT_LAST) && (r_ch == CH_LAST);
  assign o_timeout = (r_state == ST_WAIT_EOC) && w_to_hit && !w_eoc_fall;

endmodule

// File: tb/tb_max11046_read_ctrl.sv
// Directed bench for max11046_read_ctrl with a behavioural ADC and a
// negedge load/shift serializer chained on the same clock.
module tb_max11046_read_ctrl;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_start = 1'b0;
  logic        i_eoc_n = 1'b1;
  logic [15:0] i_db;
  logic        o_convst_n, o_cs_n, o_rd_n, o_endof_con, o_busy, o_done, o_timeout;
  logic [15:0] o_dout;
  logic [2:0]  o_ch;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // ADC drives the word for the channel currently being addressed.
  assign i_db = 16'hA500 + {13'd0, o_ch};

  max11046_read_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_eoc_n     (i_eoc_n),
    .i_db        (i_db),
    .o_convst_n  (o_convst_n),
    .o_cs_n      (o_cs_n),
    .o_rd_n      (o_rd_n),
    .o_dout      (o_dout),
    .o_endof_con (o_endof_con),
    .o_ch        (o_ch),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_timeout   (o_timeout)
  );

  // Serializer: loads Din while endof_con=0, shifts LSB-first while high.
  logic [15:0] ser_sh = '0;
  logic [15:0] ser_word = '0;
  logic        ser_q = 1'b0;
  int          ser_nb = 0;
  logic [15:0] ser_words[$];

  always @(negedge clk) begin
    if (o_endof_con !== 1'b1) begin
      ser_sh   = o_dout;
      ser_nb   = 0;
      ser_word = '0;
    end else begin
      ser_q            = ser_sh[0];
      ser_word[ser_nb] = ser_q;
      ser_sh           = ser_sh >> 1;
      ser_nb++;
      if (ser_nb == 16) begin
        ser_words.push_back(ser_word);
        ser_nb = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic do_reset();
    i_start = 1'b0;
    i_eoc_n = 1'b1;
    #2 i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  // Leaves the caller on the first WAIT_EOC cycle (CONVST_n just rose).
  task automatic wait_conv_rise(output bit ok);
    int n = 0;
    while (o_convst_n !== 1'b0 && n < 20) begin tick(); n++; end
    while (o_convst_n !== 1'b1 && n < 40) begin tick(); n++; end
    ok = (n < 40);
  endtask

  // Drops EOC_n after eoc_delay cycles, releases it at the first read, and
  // leaves the caller on the Done cycle.
  task automatic run_to_done(input int eoc_delay, output bit ok);
    int n = 0;
    bit rise_ok;
    wait_conv_rise(rise_ok);
    repeat (eoc_delay) tick();
    i_eoc_n = 1'b0;
    while (o_rd_n !== 1'b0 && n < 10) begin tick(); n++; end
    i_eoc_n = 1'b1;
    n = 0;
    while (o_done !== 1'b1 && n < 400) begin tick(); n++; end
    ok = rise_ok && (o_done === 1'b1);
  endtask

  task automatic test_reset();
    #2 i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_convst_n, o_cs_n, o_rd_n, o_endof_con, o_busy, o_done, o_timeout} !== 7'b1110000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 1110000",
               {o_convst_n, o_cs_n, o_rd_n, o_endof_con, o_busy, o_done, o_timeout});
    end
    n_cmp++;
    if (o_dout !== 16'h0000 || o_ch !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_data: dout %h ch %0d want 0000 / 0", o_dout, o_ch);
    end
    tick();
    i_rst_n = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (o_busy !== 1'b0 || o_convst_n !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_after_reset: busy %b convst_n %b want 0 1", o_busy, o_convst_n);
    end
  endtask

  task automatic test_frame();
    int n, rel, done_at, rd_pulses, lowrun, len_bad, cs_hi;
    logic prev_rd;
    logic [15:0] exp_w;
    ser_words.delete();
    pulse_start();
    n_cmp++;
    if (o_busy !== 1'b1 || o_convst_n !== 1'b0) begin
      n_bad++;
      $display("FAIL start_accept: busy %b convst_n %b want 1 0", o_busy, o_convst_n);
    end
    n = 0;
    while (o_convst_n === 1'b0 && n < 20) begin n++; tick(); end
    n_cmp++;
    if (n != 4) begin
      n_bad++;
      $display("FAIL convst_width: got %0d want 4", n);
    end
    repeat (50) tick();
    i_eoc_n = 1'b0;
    n = 0;
    do begin tick(); n++; end while (o_rd_n !== 1'b0 && n < 10);
    i_eoc_n = 1'b1;
    n_cmp++;
    if (n != 3) begin
      n_bad++;
      $display("FAIL eoc_latency: got %0d want 3", n);
    end
    rel = 0; done_at = -1; rd_pulses = 0; lowrun = 0; len_bad = 0; cs_hi = 0;
    prev_rd = 1'b0;
    while (done_at < 0 && rel < 400) begin
      if (o_rd_n === 1'b0) begin
        lowrun++;
      end else if (prev_rd === 1'b0) begin
        rd_pulses++;
        if (lowrun != 3) len_bad++;
        lowrun = 0;
        exp_w = 16'hA500 + 16'(rd_pulses - 1);
        n_cmp++;
        if (o_dout !== exp_w || o_endof_con !== 1'b0 || o_ch !== 3'(rd_pulses - 1)) begin
          n_bad++;
          $display("FAIL word_load: dout %h endof %b ch %0d want %h 0 %0d",
                   o_dout, o_endof_con, o_ch, exp_w, rd_pulses - 1);
        end
      end
      if (o_cs_n !== 1'b0) cs_hi++;
      if (o_done === 1'b1) done_at = rel;
      prev_rd = o_rd_n;
      if (done_at < 0) begin tick(); rel++; end
    end
    n_cmp++;
    if (done_at != 159 || rd_pulses != 8 || len_bad != 0 || cs_hi != 0) begin
      n_bad++;
      $display("FAIL burst_shape: done_at %0d rd %0d badlen %0d cs_hi %0d want 159 8 0 0",
               done_at, rd_pulses, len_bad, cs_hi);
    end
    tick();
    n_cmp++;
    if (o_cs_n !== 1'b1 || o_busy !== 1'b0 || o_ch !== 3'd0 || o_done !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_end: cs_n %b busy %b ch %0d done %b want 1 0 0 0",
               o_cs_n, o_busy, o_ch, o_done);
    end
    n_cmp++;
    if (ser_words.size() != 8) begin
      n_bad++;
      $display("FAIL ser_count: got %0d want 8", ser_words.size());
    end
    for (int i = 0; i < ser_words.size() && i < 8; i++) begin
      exp_w = 16'hA500 + 16'(i);
      n_cmp++;
      if (ser_words[i] !== exp_w) begin
        n_bad++;
        $display("FAIL ser_word%0d: got %h want %h", i, ser_words[i], exp_w);
      end
    end
  endtask

  task automatic test_timeout();
    int rel, cs_low;
    bit ok;
    pulse_start();
    wait_conv_rise(ok);
    rel = 0; cs_low = 0;
    while (o_timeout !== 1'b1 && rel < 1100) begin
      if (o_cs_n !== 1'b1) cs_low++;
      tick();
      rel++;
    end
    n_cmp++;
    if (!ok || rel != 1000 || cs_low != 0) begin
      n_bad++;
      $display("FAIL timeout_time: rel %0d cs_low %0d want 1000 0", rel, cs_low);
    end
    tick();
    n_cmp++;
    if (o_busy !== 1'b0 || o_timeout !== 1'b0 || o_cs_n !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_idle: busy %b timeout %b cs_n %b want 0 0 1", o_busy, o_timeout, o_cs_n);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lows;
    pulse_start();
    repeat (2) tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    run_to_done(20, ok);
    lows = 0;
    repeat (6) begin
      tick();
      if (o_convst_n !== 1'b1 || o_busy !== 1'b0) lows++;
    end
    n_cmp++;
    if (!ok || lows != 0) begin
      n_bad++;
      $display("FAIL start_ignored: done_seen %0d busy_cycles_after %0d want 1 0", ok, lows);
    end
    i_start = 1'b1;
    run_to_done(5, ok);
    tick();
    n_cmp++;
    if (!ok || o_busy !== 1'b0 || o_convst_n !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_gap: done_seen %0d busy %b convst_n %b want 1 0 1", ok, o_busy, o_convst_n);
    end
    tick();
    n_cmp++;
    if (o_convst_n !== 1'b0 || o_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_restart: convst_n %b busy %b want 0 1", o_convst_n, o_busy);
    end
    i_start = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int n;
    ser_words.delete();
    pulse_start();
    wait_conv_rise(ok);
    repeat (3) tick();
    i_eoc_n = 1'b0;
    n = 0;
    while (!(o_ch === 3'd3 && o_endof_con === 1'b1) && n < 200) begin tick(); n++; end
    i_eoc_n = 1'b1;
    repeat (4) tick();
    #2 i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (n >= 200 || {o_convst_n, o_cs_n, o_rd_n, o_endof_con, o_busy, o_done, o_timeout} !== 7'b1110000
        || o_dout !== 16'h0000 || o_ch !== 3'd0) begin
      n_bad++;
      $display("FAIL mid_reset: ctrl %b dout %h ch %0d want 1110000 0000 0",
               {o_convst_n, o_cs_n, o_rd_n, o_endof_con, o_busy, o_done, o_timeout}, o_dout, o_ch);
    end
    tick();
    i_rst_n = 1'b1;
    tick();
    ser_words.delete();
    pulse_start();
    run_to_done(10, ok);
    tick();
    n_cmp++;
    if (!ok || ser_words.size() != 8) begin
      n_bad++;
      $display("FAIL restart_frame: done_seen %0d words %0d want 1 8", ok, ser_words.size());
    end else if (ser_words[0] !== 16'hA500) begin
      n_bad++;
      $display("FAIL restart_ch0: got %h want a500", ser_words[0]);
    end
  endtask

  task automatic test_stale_eoc();
    bit ok;
    int rel, first_rd, n;
    i_eoc_n = 1'b0;
    repeat (5) tick();
    pulse_start();
    wait_conv_rise(ok);
    rel = 0; first_rd = -1;
    while (first_rd < 0 && rel < 60) begin
      if (o_rd_n === 1'b0) first_rd = rel;
      if (rel == 10) i_eoc_n = 1'b1;
      if (rel == 30) i_eoc_n = 1'b0;
      if (first_rd < 0) begin tick(); rel++; end
    end
    n_cmp++;
    if (!ok || first_rd != 33) begin
      n_bad++;
      $display("FAIL stale_eoc: first RD_n low at %0d want 33", first_rd);
    end
    i_eoc_n = 1'b1;
    n = 0;
    while (o_done !== 1'b1 && n < 400) begin tick(); n++; end
    n_cmp++;
    if (o_done !== 1'b1) begin
      n_bad++;
      $display("FAIL stale_done: done %b want 1", o_done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    test_stale_eoc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
